// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end for one shared registered adder.
// Accepts one operand pair per transaction, drives the adder, captures the
// registered sum and returns it tagged with the requester index.
module adder_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_in0,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  output logic [WIDTH-1:0]      add_in0,
  output logic [WIDTH-1:0]      add_in1,
  input  logic [WIDTH-1:0]      add_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]            state;
  logic [IDW-1:0]        ptr;
  logic [IDW-1:0]        gnt_idx;
  logic [IDW-1:0]        gnt_next;
  logic                  gnt_found;
  logic                  accept;
  logic [NREQ-1:0]       rot;
  logic [NREQ-1:0]       rot_k;
  logic [2*NREQ-1:0]     dbl;
  logic [NREQ*WIDTH-1:0] sh0;
  logic [NREQ*WIDTH-1:0] sh1;
  logic [WIDTH-1:0]      sel0;
  logic [WIDTH-1:0]      sel1;
  logic [WIDTH-1:0]      op0;
  logic [WIDTH-1:0]      op1;
  logic [IDW-1:0]        id_q;
  logic [WIDTH-1:0]      data_q;

  // Round-robin search: rotate req_valid so ptr sits at bit 0, take the first
  // set bit, then map the offset back to an absolute requester index.
  always_comb begin
    int unsigned s;
    int unsigned nx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    s         = 0;
    dbl       = {req_valid, req_valid} >> ptr;
    rot       = dbl[NREQ-1:0];
    rot_k     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rot_k = rot >> k;
      if (!gnt_found && rot_k[0]) begin
        gnt_found = 1'b1;
        s = 32'(ptr) + k;
        if (s >= NREQ) s = s - NREQ;
        gnt_idx = IDW'(s);
      end
    end
    nx = 32'(gnt_idx) + 1;
    if (nx >= NREQ) nx = 0;
    gnt_next = IDW'(nx);
  end

  // Grant is only offered in IDLE; at most one bit is ever high.
  always_comb begin
    accept    = reset_n && (state == IDLE) && gnt_found;
    req_ready = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    sh0       = req_in0 >> (32'(gnt_idx) * WIDTH);
    sh1       = req_in1 >> (32'(gnt_idx) * WIDTH);
    sel0      = sh0[WIDTH-1:0];
    sel1      = sh1[WIDTH-1:0];
  end

  // Sequencer: latch winner, wait for adder latency, hold response until taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ptr    <= '0;
      op0    <= '0;
      op1    <= '0;
      id_q   <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op0   <= sel0;
            op1   <= sel1;
            id_q  <= gnt_idx;
            ptr   <= gnt_next;
            state <= ISSUE;
          end
        end
        ISSUE:   state <= CAPTURE;
        CAPTURE: begin
          data_q <= add_out;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are plain decodes of registered state.
  always_comb begin
    add_in0   = op0;
    add_in1   = op1;
    rsp_id    = id_q;
    rsp_data  = data_q;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural registered adder.
module tb_adder_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_in0;
  logic [31:0] req_in1;
  logic [7:0]  add_in0;
  logic [7:0]  add_in1;
  logic [7:0]  add_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  adder_arbiter #(.WIDTH(8), .NREQ(4), .IDW(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in0(req_in0), .req_in1(req_in1),
    .add_in0(add_in0), .add_in1(add_in1), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Behavioural registered adder.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) add_out <= 8'd0;
    else          add_out <= add_in0 + add_in1;
  end

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_in0[i*8 +: 8] = a;
    req_in1[i*8 +: 8] = b;
  endtask

  // Waits (bounded) for a grant; called at a falling edge, samples 1 time unit later.
  task automatic wait_grant(output bit ok, output int g);
    ok = 1'b0;
    g  = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != 4'd0) begin
        ok = 1'b1;
        for (int j = 0; j < 4; j++) if (req_ready[j]) g = j;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_id, rsp_data, add_in0, add_in1} !== 33'd0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b id=%0d data=%0d a0=%0d a1=%0d expected all 0",
               req_ready, rsp_valid, busy, rsp_id, rsp_data, add_in0, add_in1);
    else passes++;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else passes++;
  endtask

  task automatic test_single();
    bit ok; int g;
    @(negedge clock);
    set_op(1, 8'd3, 8'd4);
    req_valid = 4'b0010;
    wait_grant(ok, g);
    checks++;
    if (g != 1) $display("FAIL single_grant: got %0d expected 1", g); else passes++;
    @(negedge clock); req_valid = 4'b0000; #1;
    checks++;
    if (add_in0 !== 8'd3 || add_in1 !== 8'd4 || busy !== 1'b1 || req_ready !== 4'd0)
      $display("FAIL single_issue: got a0=%0d a1=%0d busy=%b rdy=%b expected 3 4 1 0000",
               add_in0, add_in1, busy, req_ready);
    else passes++;
    @(negedge clock); #1;
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL single_early_rsp: got %b expected 0", rsp_valid);
    else passes++;
    @(negedge clock); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'd7)
      $display("FAIL single_rsp: got vld=%b id=%0d data=%0d expected 1 1 7", rsp_valid, rsp_id, rsp_data);
    else passes++;
    @(negedge clock); #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b expected 0", busy); else passes++;
  endtask

  task automatic test_all_at_once();
    bit ok; int g; int prev;
    prev = 0;
    @(negedge clock);
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 10), 8'(i + 10));
    req_valid = 4'b1111;
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_grant(ok, g);
      checks++;
      if (g != n) $display("FAIL all_grant%0d: got %0d expected %0d", n, g, n); else passes++;
      if (n > 0) begin
        checks++;
        if (cyc - prev != 4) $display("FAIL all_interval%0d: got %0d expected 4", n, cyc - prev);
        else passes++;
      end
      prev = cyc;
      @(negedge clock); req_valid[n] = 1'b0;
      @(negedge clock);
      @(negedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(n) || rsp_data !== 8'(20 + 2 * n))
        $display("FAIL all_rsp%0d: got vld=%b id=%0d data=%0d expected 1 %0d %0d",
                 n, rsp_valid, rsp_id, rsp_data, n, 20 + 2 * n);
      else passes++;
      @(negedge clock);
    end
  endtask

  task automatic test_fairness();
    bit ok; int g;
    @(negedge clock);
    set_op(2, 8'd1, 8'd2);
    req_valid = 4'b0100;
    wait_grant(ok, g);
    checks++;
    if (g != 2) $display("FAIL fair_first: got %0d expected 2", g); else passes++;
    @(negedge clock); req_valid = 4'b0000;
    @(negedge clock);
    @(negedge clock);
    set_op(0, 8'd5, 8'd5);
    set_op(3, 8'd6, 8'd6);
    req_valid = 4'b1001;
    @(negedge clock);
    wait_grant(ok, g);
    checks++;
    if (g != 3) $display("FAIL fair_second: got %0d expected 3", g); else passes++;
    @(negedge clock); req_valid[3] = 1'b0;
    @(negedge clock);
    @(negedge clock); #1;
    checks++;
    if (rsp_id !== 2'd3 || rsp_data !== 8'd12)
      $display("FAIL fair_rsp3: got id=%0d data=%0d expected 3 12", rsp_id, rsp_data);
    else passes++;
    @(negedge clock);
    wait_grant(ok, g);
    checks++;
    if (g != 0) $display("FAIL fair_third: got %0d expected 0", g); else passes++;
    @(negedge clock); req_valid = 4'b0000;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_overflow();
    bit ok; int g;
    logic [7:0] va [2];
    logic [7:0] vb [2];
    logic [7:0] ve [2];
    va[0] = 8'd200; vb[0] = 8'd100; ve[0] = 8'd44;
    va[1] = 8'd255; vb[1] = 8'd1;   ve[1] = 8'd0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clock);
      set_op(n + 1, va[n], vb[n]);
      req_valid = 4'(1 << (n + 1));
      wait_grant(ok, g);
      checks++;
      if (g != n + 1) $display("FAIL ovf_grant%0d: got %0d expected %0d", n, g, n + 1); else passes++;
      @(negedge clock); req_valid = 4'b0000;
      @(negedge clock);
      @(negedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== ve[n])
        $display("FAIL ovf_data%0d: got vld=%b data=%0d expected 1 %0d", n, rsp_valid, rsp_data, ve[n]);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    bit ok; int g;
    @(negedge clock);
    rsp_ready = 1'b0;
    set_op(2, 8'd5, 8'd6);
    set_op(0, 8'd1, 8'd1);
    req_valid = 4'b0100;
    wait_grant(ok, g);
    checks++;
    if (g != 2) $display("FAIL bp_grant: got %0d expected 2", g); else passes++;
    @(negedge clock); req_valid = 4'b0001;
    @(negedge clock);
    for (int n = 0; n < 5; n++) begin
      @(negedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'd11 || req_ready !== 4'd0 || busy !== 1'b1)
        $display("FAIL bp_hold%0d: got vld=%b id=%0d data=%0d rdy=%b busy=%b expected 1 2 11 0000 1",
                 n, rsp_valid, rsp_id, rsp_data, req_ready, busy);
      else passes++;
    end
    rsp_ready = 1'b1;
    @(negedge clock); #1;
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL bp_next_accept: got %b expected 0001", req_ready);
    else passes++;
    @(negedge clock); req_valid = 4'b0000;
    @(negedge clock);
    @(negedge clock); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'd2)
      $display("FAIL bp_rsp0: got vld=%b id=%0d data=%0d expected 1 0 2", rsp_valid, rsp_id, rsp_data);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit ok; int g;
    @(negedge clock);
    set_op(1, 8'd9, 8'd9);
    req_valid = 4'b0010;
    wait_grant(ok, g);
    checks++;
    if (g != 1) $display("FAIL rmid_grant: got %0d expected 1", g); else passes++;
    @(negedge clock); req_valid = 4'b0000;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_id, rsp_data, add_in0, add_in1} !== 33'd0)
      $display("FAIL rmid_outputs: got rdy=%b vld=%b busy=%b id=%0d data=%0d a0=%0d a1=%0d expected all 0",
               req_ready, rsp_valid, busy, rsp_id, rsp_data, add_in0, add_in1);
    else passes++;
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b0) $display("FAIL rmid_no_rsp%0d: got %b expected 0", n, rsp_valid);
      else passes++;
    end
    @(negedge clock);
    set_op(0, 8'd7, 8'd8);
    set_op(3, 8'd1, 8'd2);
    req_valid = 4'b1001;
    wait_grant(ok, g);
    checks++;
    if (g != 0) $display("FAIL rmid_ptr_reset: got %0d expected 0", g); else passes++;
    @(negedge clock); req_valid = 4'b0000;
    @(negedge clock);
    @(negedge clock); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'd15)
      $display("FAIL rmid_rsp: got vld=%b id=%0d data=%0d expected 1 0 15", rsp_valid, rsp_id, rsp_data);
    else passes++;
    @(negedge clock);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_in0   = 32'd0;
    req_in1   = 32'd0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_all_at_once();
    test_fairness();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
